// File: rtl/md_pkg.sv
// rtl/md_pkg.sv - shared op encodings, state enum and helpers for the mul/div sequencer
package md_pkg;

  localparam int MD_STEPS = 32;

  localparam logic [2:0] MD_NOP   = 3'd0;
  localparam logic [2:0] MD_MULT  = 3'd1;
  localparam logic [2:0] MD_MULTU = 3'd2;
  localparam logic [2:0] MD_DIV   = 3'd3;
  localparam logic [2:0] MD_DIVU  = 3'd4;
  localparam logic [2:0] MD_MTHI  = 3'd5;
  localparam logic [2:0] MD_MTLO  = 3'd6;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } md_state_t;

  // True for the four ops that run the iterative loop.
  function automatic logic md_is_arith(input logic [2:0] op);
    return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
  endfunction

  // Magnitude of a two's-complement value when is_signed is set, else unchanged.
  function automatic logic [31:0] md_abs(input logic [31:0] v, input logic is_signed);
    return (is_signed && v[31]) ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/md_step.sv
// rtl/md_step.sv - one shift-add multiply or restoring-divide iteration
module md_step #(
  parameter int WIDTH = 32
) (
  input  logic               is_div,
  input  logic [2*WIDTH-1:0] acc,
  input  logic [WIDTH-1:0]   operand,
  output logic [2*WIDTH-1:0] acc_next
);

  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   rem_sh;
  logic             fits;
  logic [WIDTH-1:0] rem_sub;

  // Multiply: acc = {partial product, remaining multiplier bits}; add on LSB then shift right.
  // Divide:   acc = {partial remainder, remaining dividend/quotient bits}; shift left then trial-subtract.
  always_comb begin
    acc_next = acc;
    mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, operand} : '0);
    rem_sh   = acc[2*WIDTH-1:WIDTH-1];
    fits     = (rem_sh >= {1'b0, operand});
    rem_sub  = rem_sh[WIDTH-1:0] - operand;
    if (is_div) begin
      acc_next = {(fits ? rem_sub : rem_sh[WIDTH-1:0]), acc[WIDTH-2:0], fits};
    end else begin
      acc_next = {mul_sum, acc[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/md_seq.sv
// rtl/md_seq.sv - iterative mul/div sequencer owning HI/LO; MD_CANCEL_EN adds a cancel input
module md_seq
  import md_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
`ifdef MD_CANCEL_EN
  input  logic             cancel,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CNT_W = $clog2(MD_STEPS);
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(MD_STEPS - 1);

  md_state_t          state_q, state_d;
  logic [CNT_W-1:0]   counter;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] acc_step;
  logic [WIDTH-1:0]   operand_q;
  logic               is_div_q;
  logic               neg_res_q;
  logic               neg_rem_q;

  logic               cancel_w;
  logic               accept;
  logic               mthi_en;
  logic               mtlo_en;
  logic               step_en;
  logic               fix_en;

  logic               ld_signed;
  logic               ld_div;
  logic               ld_div_zero;
  logic [WIDTH-1:0]   ld_a;
  logic [WIDTH-1:0]   ld_b;
  logic               ld_neg_res;
  logic               ld_neg_rem;

  logic [2*WIDTH-1:0] prod_neg;
  logic [WIDTH-1:0]   quo_neg;
  logic [WIDTH-1:0]   rem_neg;

`ifdef MD_CANCEL_EN
  assign cancel_w = cancel;
`else
  assign cancel_w = 1'b0;
`endif

  md_step #(.WIDTH(WIDTH)) u_step (
    .is_div   (is_div_q),
    .acc      (acc),
    .operand  (operand_q),
    .acc_next (acc_step)
  );

  // Operand preparation for an accepted op: loop runs on magnitudes, sign fix deferred to FIX.
  // A zero divisor keeps the raw dividend so the remainder comes out as a, with no sign fix.
  always_comb begin
    ld_signed   = (op == MD_MULT) || (op == MD_DIV);
    ld_div      = (op == MD_DIV) || (op == MD_DIVU);
    ld_div_zero = ld_div && (b == '0);
    ld_a        = ld_div_zero ? a : md_abs(a, ld_signed);
    ld_b        = md_abs(b, ld_signed);
    ld_neg_res  = ld_signed && (a[WIDTH-1] ^ b[WIDTH-1]) && !ld_div_zero;
    ld_neg_rem  = ld_signed && ld_div && a[WIDTH-1] && !ld_div_zero;
  end

  // Next-state and per-cycle enables; start is only honoured in IDLE.
  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    mthi_en = 1'b0;
    mtlo_en = 1'b0;
    step_en = 1'b0;
    fix_en  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start && md_is_arith(op)) begin
          accept  = 1'b1;
          state_d = RUN;
        end else if (start && (op == MD_MTHI)) begin
          mthi_en = 1'b1;
        end else if (start && (op == MD_MTLO)) begin
          mtlo_en = 1'b1;
        end
      end
      RUN: begin
        if (cancel_w) begin
          state_d = IDLE;
        end else begin
          step_en = 1'b1;
          if (counter == LAST_STEP) begin
            state_d = FIX;
          end
        end
      end
      FIX: begin
        state_d = IDLE;
        fix_en  = !cancel_w;
      end
      default: state_d = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Registered status: busy follows the next state, done marks the HI/LO write.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      busy    <= 1'b0;
      done    <= 1'b0;
      counter <= '0;
    end else begin
      busy <= (state_d != IDLE);
      done <= fix_en;
      if (accept) begin
        counter <= '0;
      end else if (step_en) begin
        counter <= counter + 1'b1;
      end
    end
  end

  // Operand latch on accept, one datapath iteration per RUN cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc       <= '0;
      operand_q <= '0;
      is_div_q  <= 1'b0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
    end else if (accept) begin
      is_div_q  <= ld_div;
      neg_res_q <= ld_neg_res;
      neg_rem_q <= ld_neg_rem;
      if (ld_div) begin
        acc       <= {{WIDTH{1'b0}}, ld_a};
        operand_q <= ld_b;
      end else begin
        acc       <= {{WIDTH{1'b0}}, ld_b};
        operand_q <= ld_a;
      end
    end else if (step_en) begin
      acc <= acc_step;
    end
  end

  assign prod_neg = ~acc + 1'b1;
  assign quo_neg  = ~acc[WIDTH-1:0] + 1'b1;
  assign rem_neg  = ~acc[2*WIDTH-1:WIDTH] + 1'b1;

  // HI/LO: direct moves in IDLE, sign-corrected result in FIX, otherwise held.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hi <= '0;
      lo <= '0;
    end else if (fix_en) begin
      if (is_div_q) begin
        lo <= neg_res_q ? quo_neg : acc[WIDTH-1:0];
        hi <= neg_rem_q ? rem_neg : acc[2*WIDTH-1:WIDTH];
      end else begin
        {hi, lo} <= neg_res_q ? prod_neg : acc;
      end
    end else if (mthi_en) begin
      hi <= a;
    end else if (mtlo_en) begin
      lo <= a;
    end
  end

endmodule

// File: tb/tb_md_seq.sv
// tb/tb_md_seq.sv - scoreboard bench for md_seq
module tb_md_seq;
  import md_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [2:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;
`ifdef MD_CANCEL_EN
  logic        cancel;
`endif

  md_seq #(.WIDTH(32)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .op    (op),
    .a     (a),
    .b     (b),
`ifdef MD_CANCEL_EN
    .cancel(cancel),
`endif
    .busy  (busy),
    .done  (done),
    .hi    (hi),
    .lo    (lo)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          cyc;
    string       name;
  } exp_t;

  exp_t sb[$];
  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Monitor: every done pulse must match the oldest expected result.
  always @(negedge clk) begin
    exp_t e;
    if (reset === 1'b1 && done === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL spurious_done actual=1 required=0");
      end else begin
        e = sb.pop_front();
        check({e.name, "_hi"}, hi, e.hi);
        check({e.name, "_lo"}, lo, e.lo);
        check({e.name, "_latency"}, cyc, e.cyc);
      end
    end
  end

  task automatic run_op(input string name, input logic [2:0] o, input logic [31:0] av,
                        input logic [31:0] bv, input logic [31:0] eh, input logic [31:0] el,
                        input int inj_at, input logic [2:0] inj_op);
    exp_t        e;
    int          bc;
    bit          hold_ok;
    logic [31:0] ph;
    logic [31:0] pl;
    @(negedge clk);
    ph = hi;
    pl = lo;
    e.hi = eh;
    e.lo = el;
    e.cyc = cyc + 34;
    e.name = name;
    sb.push_back(e);
    start = 1'b1;
    op = o;
    a = av;
    b = bv;
    bc = 0;
    hold_ok = 1'b1;
    for (int i = 1; i <= 60; i++) begin
      @(negedge clk);
      start = 1'b0;
      op = MD_NOP;
      a = 32'hDEADBEEF;
      b = 32'h0BAD0BAD;
      if (!busy) break;
      bc++;
      if (hi !== ph || lo !== pl) hold_ok = 1'b0;
      if (i == inj_at) begin
        start = 1'b1;
        op = inj_op;
        a = 32'h55AA55AA;
        b = 32'h00000003;
      end
    end
    start = 1'b0;
    check({name, "_busy_len"}, bc, 33);
    check({name, "_hold"}, hold_ok, 1);
  endtask

  task automatic idle_op(input string name, input logic [2:0] o, input logic [31:0] av,
                         input logic [31:0] eh, input logic [31:0] el);
    @(negedge clk);
    start = 1'b1;
    op = o;
    a = av;
    @(negedge clk);
    start = 1'b0;
    op = MD_NOP;
    check({name, "_hi"}, hi, eh);
    check({name, "_lo"}, lo, el);
    check({name, "_busy"}, busy, 0);
    check({name, "_done"}, done, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout actual=running required=finished");
    $fatal;
  end

  initial begin
    logic [31:0] ph;
    logic [31:0] pl;
    reset = 1'b0;
    start = 1'b0;
    op = MD_NOP;
    a = '0;
    b = '0;
`ifdef MD_CANCEL_EN
    cancel = 1'b0;
`endif
    @(negedge clk);
    check("rst_hi", hi, 0);
    check("rst_lo", lo, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    @(negedge clk);
    reset = 1'b1;

    idle_op("mthi", MD_MTHI, 32'h12345678, 32'h12345678, 32'h0);
    idle_op("mtlo", MD_MTLO, 32'hCAFEF00D, 32'h12345678, 32'hCAFEF00D);
    idle_op("nop", MD_NOP, 32'h11111111, 32'h12345678, 32'hCAFEF00D);
    idle_op("op7", 3'd7, 32'h22222222, 32'h12345678, 32'hCAFEF00D);

    run_op("mult_m1x2", MD_MULT, 32'hFFFFFFFF, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFE, 7, MD_MTLO);
    run_op("multu_x2", MD_MULTU, 32'hFFFFFFFF, 32'd2, 32'h00000001, 32'hFFFFFFFE, 0, MD_NOP);
    run_op("div_m7d2", MD_DIV, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 0, MD_NOP);
    run_op("divu_100d7", MD_DIVU, 32'd100, 32'd7, 32'd2, 32'd14, 0, MD_NOP);
    run_op("divu_by0", MD_DIVU, 32'd5, 32'd0, 32'd5, 32'hFFFFFFFF, 0, MD_NOP);
    run_op("div_ovf", MD_DIV, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000, 0, MD_NOP);
    run_op("mult_inj_div", MD_MULT, 32'h00012345, 32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFC9631, 5, MD_DIV);
    run_op("div_neg_by0", MD_DIV, 32'hFFFFFFF0, 32'd0, 32'hFFFFFFF0, 32'hFFFFFFFF, 0, MD_NOP);
    run_op("multu_max", MD_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 32, MD_MTHI);
    run_op("div_7dm2", MD_DIV, 32'd7, 32'hFFFFFFFE, 32'd1, 32'hFFFFFFFD, 0, MD_NOP);

    // Asynchronous reset in the middle of a multiply.
    @(negedge clk);
    start = 1'b1;
    op = MD_MULT;
    a = 32'd3;
    b = 32'd5;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    check("pre_rst_busy", busy, 1);
    #1;
    reset = 1'b0;
    #1;
    check("midrst_hi", hi, 0);
    check("midrst_lo", lo, 0);
    check("midrst_busy", busy, 0);
    check("midrst_done", done, 0);
    @(negedge clk);
    reset = 1'b1;
    run_op("multu_after_rst", MD_MULTU, 32'd3, 32'd5, 32'd0, 32'd15, 0, MD_NOP);

`ifdef MD_CANCEL_EN
    @(negedge clk);
    ph = hi;
    pl = lo;
    start = 1'b1;
    op = MD_MULTU;
    a = 32'd2;
    b = 32'd3;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    cancel = 1'b1;
    @(negedge clk);
    cancel = 1'b0;
    check("cancel_busy", busy, 0);
    check("cancel_hi", hi, ph);
    check("cancel_lo", lo, pl);
    repeat (40) @(negedge clk);
    check("cancel_hold_hi", hi, ph);
    run_op("mult_after_cancel", MD_MULT, 32'hFFFFFFFD, 32'hFFFFFFFD, 32'd0, 32'd9, 0, MD_NOP);
`else
    ph = hi;
    pl = lo;
    check("end_hi", hi, ph);
    check("end_lo", lo, pl);
`endif

    repeat (3) @(negedge clk);
    check("sb_empty", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/md_seq.md
Name: md_seq

Overview:
- Iterative multiply/divide sequencer owning the HI/LO register pair; replaces the combinational multiply/divide path and separate HI/LO holders.
- Accepts one operation from the main control FSM via start/op, runs a 32-step shift-add or restoring-divide loop, then writes HI/LO.
- busy stalls the control FSM.

Parameters:
- WIDTH, 32, operand width; only 32 is supported. The step counter is 5 bits, derived as log2(WIDTH).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset (asserted when 0).
- start  input  1  one-cycle request; sampled only in IDLE.
- op  input  3  0 NOP, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 reserved (treated as NOP).
- a  input  32  rs operand: multiplicand, dividend, or MTHI/MTLO source.
- b  input  32  rt operand: multiplier or divisor.
- busy  output  1  high from the cycle after an accepted MULT/DIV through the FIX cycle inclusive.
- done  output  1  one-cycle pulse in the cycle HI/LO first show the new result.
- hi  output  32  HI register.
- lo  output  32  LO register.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE, hi=0, lo=0, busy=0, done=0, counter=0.
  - Reset during RUN or FIX aborts the operation. HI/LO end up 0.
- States:
  - IDLE: start && op in 1..4 -> latch operands and signs, counter=0, go to RUN. start && op 5/6 -> hi<=a or lo<=a at that edge; stay IDLE; no busy, no done. Otherwise stay IDLE.
  - RUN: one iteration per clock. At counter==31, go to FIX; otherwise counter+1.
  - FIX: apply sign correction, write HI/LO, assert done (registered), go to IDLE.
- Latency: start sampled at edge E0. busy=1 after E0. Iteration edges are E1..E32. FIX ends at E33, which writes HI/LO, sets done=1 and busy=0. done is seen for exactly one cycle. The next start can be accepted at E34.
- Multiply:
  - MULTU: 64-bit unsigned product; HI=upper 32 bits, LO=lower 32 bits.
  - MULT: iterate on magnitudes, then negate the 64-bit product in FIX if the operand signs differ.
- Divide:
  - DIVU: LO=quotient, HI=remainder.
  - DIV: quotient truncates toward zero; remainder takes the dividend's sign; negation happens in FIX.
- Divide by zero: no early exit; full latency still applies.
  - DIVU: HI=a, LO=0xFFFFFFFF.
  - DIV: HI=a, LO=0xFFFFFFFF. Sign fix is suppressed.
- Overflow: DIV 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0 (wrap, no trap).
- Requests while busy: start in RUN/FIX is ignored (any op, including MTHI/MTLO). The control FSM must hold the instruction until busy=0.
- Reads: hi/lo hold their old values throughout RUN/FIX. MFHI/MFLO issued while busy must be stalled by the control FSM.
- Outputs are registered; nothing combinational flows from inputs to outputs.

Optional Feature:
- Macro: MD_CANCEL_EN.
- Defined: adds input port cancel (1 bit), for exception entry. If cancel=1 in RUN or FIX, the sequencer goes to IDLE at the next edge: busy=0, no done, HI/LO unchanged. cancel in IDLE has no effect. cancel and start in the same IDLE cycle: start wins.
- Undefined: no cancel port; an operation always completes.

Decomposition:
- Package md_pkg:
  - op encodings MD_NOP..MD_MTLO.
  - state enum IDLE/RUN/FIX (2 bits).
  - MD_STEPS=32.
- Sub-module md_step: combinational single-iteration datapath. It takes the partial remainder/product and the operand and returns the next partial value. It performs add-and-shift for multiply and trial-subtract-and-shift for divide, selected by a mode bit.
- md_seq holds the FSM, counter, sign flags and HI/LO.

Test Plan:
- MULT a=0xFFFFFFFF, b=2 -> done 33 clocks after start; HI=0xFFFFFFFF, LO=0xFFFFFFFE. MULTU same operands -> HI=0x00000001, LO=0xFFFFFFFE.
- DIV a=0xFFFFFFF9 (-7), b=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU a=100, b=7 -> LO=14, HI=2.
- DIVU a=5, b=0 -> HI=5, LO=0xFFFFFFFF after full latency. DIV 0x80000000/0xFFFFFFFF -> LO=0x80000000, HI=0.
- MTHI a=0x12345678 in IDLE -> hi=0x12345678 next cycle, busy and done stay 0. MTLO pulsed during RUN -> lo unchanged.
- start MULT, then start DIV at cycle 5 -> DIV ignored; MULT result correct; busy continuous from E0 to E33; a single done pulse.
- reset=0 at iteration 10 -> hi=lo=0 and busy=0 immediately. With MD_CANCEL_EN: cancel at iteration 10 -> IDLE next edge, HI/LO keep their prior values, no done.
